// File: rtl/xor_cipher_pkg.sv
// Shared definitions for the XOR stream cipher link: keystream width, FSM states
// and the Galois keystream step used by both the transmit and receive ends.
package xor_cipher_pkg;

  localparam int LFSR_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // One Galois step: shift right, fold the tap mask in when the outgoing bit is 1.
  function automatic logic [LFSR_W-1:0] ks_next(input logic [LFSR_W-1:0] state,
                                                input logic [LFSR_W-1:0] taps);
    ks_next = state[0] ? ((state >> 1) ^ taps) : (state >> 1);
  endfunction

endpackage

// File: rtl/keystream_gen.sv
// 32-bit Galois keystream register; load takes priority over advance.
module keystream_gen
  import xor_cipher_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              adv,
  input  logic [LFSR_W-1:0] taps,
  output logic              ks_bit
);

  logic [LFSR_W-1:0] ks_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ks_reg <= '0;
    end else if (load) begin
      ks_reg <= seed;
    end else if (adv) begin
      ks_reg <= ks_next(ks_reg, taps);
    end
  end

  assign ks_bit = ks_reg[0];

endmodule

// File: rtl/xor_cipher_rx.sv
// Serial XOR-cipher decryptor: regenerates the keystream, assembles LSB-first words
// and hands them out over valid/ready. XOR_CIPHER_RX_PARITY_EN adds a trailing parity bit.
module xor_cipher_rx
  import xor_cipher_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LFSR_W-1:0] seed,
  input  logic [LFSR_W-1:0] taps,
  input  logic              start,
  input  logic              stop,
  input  logic              ct_bit,
  input  logic              ct_valid,
  output logic [DATA_W-1:0] pt_data,
  output logic              pt_valid,
  input  logic              pt_ready,
  output logic              overrun,
  output logic              parity_err,
  output logic              busy
);

`ifdef XOR_CIPHER_RX_PARITY_EN
  localparam int FRAME_W = DATA_W + 1;
`else
  localparam int FRAME_W = DATA_W;
`endif
  localparam int CNT_W = $clog2(FRAME_W + 1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   bit_cnt_reg;
  logic [FRAME_W-1:0] shift_reg;
  logic [FRAME_W-1:0] frame_word;
  logic [DATA_W-1:0]  pt_data_reg;
  logic               pt_valid_reg;
  logic               overrun_reg;
  logic               ks_bit;
  logic               accept, pt_bit, last_bit, complete, slot_free, word_perr;

  always_comb begin
    state_next = state_reg;
    if (start) begin
      state_next = RUN;
    end else if (stop) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // A bit arriving alongside start or stop is discarded.
  assign accept    = (state_reg == RUN) && ct_valid && !start && !stop;
  assign pt_bit    = ct_bit ^ ks_bit;
  assign last_bit  = (bit_cnt_reg == CNT_W'(FRAME_W - 1));
  assign complete  = accept && last_bit;
  assign slot_free = !pt_valid_reg || pt_ready;

  // Current frame contents with this cycle's bit dropped into its slot.
  always_comb begin
    frame_word = shift_reg;
    for (int i = 0; i < FRAME_W; i++) begin
      if (bit_cnt_reg == CNT_W'(i)) begin
        frame_word[i] = pt_bit;
      end
    end
  end

`ifdef XOR_CIPHER_RX_PARITY_EN
  logic parity_err_reg;
  assign word_perr  = ^frame_word;
  assign parity_err = parity_err_reg;
`else
  assign word_perr  = 1'b0;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      pt_data_reg  <= '0;
      pt_valid_reg <= 1'b0;
      overrun_reg  <= 1'b0;
    end else if (start) begin
      bit_cnt_reg  <= '0;
      pt_valid_reg <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      if (stop) begin
        bit_cnt_reg <= '0;
      end else if (accept) begin
        shift_reg   <= frame_word;
        bit_cnt_reg <= last_bit ? '0 : bit_cnt_reg + CNT_W'(1);
      end
      if (complete && slot_free) begin
        pt_data_reg  <= frame_word[DATA_W-1:0];
        pt_valid_reg <= 1'b1;
      end else begin
        if (complete) begin
          overrun_reg <= 1'b1;
        end
        if (pt_valid_reg && pt_ready) begin
          pt_valid_reg <= 1'b0;
        end
      end
    end
  end

`ifdef XOR_CIPHER_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err_reg <= 1'b0;
    end else if (!start && complete && slot_free) begin
      parity_err_reg <= word_perr;
    end
  end
`endif

  keystream_gen u_keystream (
    .clk    (clk),
    .rst    (rst),
    .load   (start),
    .seed   (seed),
    .adv    (accept),
    .taps   (taps),
    .ks_bit (ks_bit)
  );

  assign pt_data  = pt_data_reg;
  assign pt_valid = pt_valid_reg;
  assign overrun  = overrun_reg;
  assign busy     = (state_reg == RUN);

endmodule

// File: tb/tb_xor_cipher_rx.sv
// Scoreboard bench for xor_cipher_rx: directed link cases plus a randomized encrypted
// stream. Build with XOR_CIPHER_RX_PARITY_EN defined to cover the parity frame format.
module tb_xor_cipher_rx;
  import xor_cipher_pkg::*;

  localparam int DATA_W = 8;
`ifdef XOR_CIPHER_RX_PARITY_EN
  localparam int FRAME_W = DATA_W + 1;
`else
  localparam int FRAME_W = DATA_W;
`endif

  logic        clk = 1'b0;
  logic        rst, start, stop, ct_bit, ct_valid, pt_ready;
  logic [31:0] seed, taps;
  logic [DATA_W-1:0] pt_data;
  logic        pt_valid, overrun, parity_err, busy;

  int tests = 0;
  int fails = 0;
  int words = 0;
  logic [DATA_W:0] exp_q[$];   // {parity_err, data}

  always #5 clk = ~clk;

  xor_cipher_rx #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .seed       (seed),
    .taps       (taps),
    .start      (start),
    .stop       (stop),
    .ct_bit     (ct_bit),
    .ct_valid   (ct_valid),
    .pt_data    (pt_data),
    .pt_valid   (pt_valid),
    .pt_ready   (pt_ready),
    .overrun    (overrun),
    .parity_err (parity_err),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake consumes the oldest expected word.
  always @(negedge clk) begin
    if (!rst && pt_valid && pt_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word: got 0x%0h, expected no word", pt_data);
      end else begin
        logic [DATA_W:0] e;
        e = exp_q.pop_front();
        words++;
        $display("[TB] word %0d data=0x%02h perr=%0b exp=0x%02h/%0b",
                 words, pt_data, parity_err, e[DATA_W-1:0], e[DATA_W]);
        check("word_data", 32'(pt_data), 32'(e[DATA_W-1:0]));
        check("word_perr", 32'(parity_err), 32'(e[DATA_W]));
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] s);
    seed     = s;
    start    = 1'b1;
    ct_valid = 1'b0;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    ct_bit   = b;
    ct_valid = 1'b1;
    tick();
    ct_valid = 1'b0;
  endtask

  // Frame vector is {parity, data}; only the low FRAME_W bits go on the wire.
  task automatic send_bits(input logic [DATA_W:0] fr, input int from, input int to);
    for (int i = from; i < to; i++) send_bit(fr[i]);
  endtask

  initial begin
    logic [31:0]       mks;
    logic [DATA_W-1:0] pt;
    logic [DATA_W:0]   fr;
    logic              flip;

    rst = 1'b1; start = 1'b0; stop = 1'b0; ct_bit = 1'b0; ct_valid = 1'b0;
    pt_ready = 1'b0; seed = '0; taps = '0;
    tick(); tick();
    check("rst_pt_valid", 32'(pt_valid), 0);
    check("rst_pt_data", 32'(pt_data), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_parity_err", 32'(parity_err), 0);
    rst = 1'b0;
    tick();

    // Basic decrypt with consumer always ready.
    pt_ready = 1'b1;
    do_start(32'h0000_00A5);
    check("t1_busy", 32'(busy), 1);
    exp_q.push_back({1'b0, 8'hFF});
    send_bits({1'b0, 8'h5A}, 0, FRAME_W - 1);
    check("t1_early", 32'(pt_valid), 0);
    send_bits({1'b0, 8'h5A}, FRAME_W - 1, FRAME_W);
    check("t1_lat1", 32'(pt_valid), 1);
    exp_q.push_back({1'b0, 8'h3C});
    send_bits({1'b0, 8'h3C}, 0, FRAME_W);
    check("t1_lat2", 32'(pt_valid), 1);
    tick();
    check("t1_drained", 32'(pt_valid), 0);
    check("t1_overrun", 32'(overrun), 0);

    // Consumer becomes ready in the cycle the second word completes.
    pt_ready = 1'b0;
    do_start(32'h0000_00A5);
    send_bits({1'b0, 8'h5A}, 0, FRAME_W);
    check("t3_first", 32'(pt_data), 32'hFF);
    send_bits({1'b0, 8'h3C}, 0, FRAME_W - 1);
    exp_q.push_back({1'b0, 8'hFF});
    exp_q.push_back({1'b0, 8'h3C});
    pt_ready = 1'b1;
    send_bits({1'b0, 8'h3C}, FRAME_W - 1, FRAME_W);
    check("t3_valid", 32'(pt_valid), 1);
    check("t3_data", 32'(pt_data), 32'h3C);
    check("t3_overrun", 32'(overrun), 0);
    tick();

    // Consumer never ready: second word is dropped.
    pt_ready = 1'b0;
    do_start(32'h0000_00A5);
    send_bits({1'b0, 8'h5A}, 0, FRAME_W);
    check("t2_data1", 32'(pt_data), 32'hFF);
    check("t2_overrun1", 32'(overrun), 0);
    send_bits({1'b0, 8'h3C}, 0, FRAME_W);
    check("t2_overrun2", 32'(overrun), 1);
    check("t2_data2", 32'(pt_data), 32'hFF);
    check("t2_valid2", 32'(pt_valid), 1);

    // Restart mid-frame discards the partial word and clears overrun.
    send_bits({1'b0, 8'h5A}, 0, 3);
    do_start(32'h0000_00FF);
    check("t4_overrun", 32'(overrun), 0);
    check("t4_valid", 32'(pt_valid), 0);
    pt_ready = 1'b1;
    exp_q.push_back({1'b0, 8'hFF});
    send_bits({1'b0, 8'h00}, 0, FRAME_W);
    check("t4_data", 32'(pt_data), 32'hFF);
    tick();

`ifdef XOR_CIPHER_RX_PARITY_EN
    do_start(32'h0);
    exp_q.push_back({1'b1, 8'h01});
    send_bits({1'b0, 8'h01}, 0, FRAME_W);
    check("par_err1", 32'(parity_err), 1);
    exp_q.push_back({1'b0, 8'h03});
    send_bits({1'b0, 8'h03}, 0, FRAME_W);
    check("par_err0", 32'(parity_err), 0);
    tick();
`endif

    // Randomized encrypted stream with gaps and stop/start resynchronisation.
    taps = $urandom;
    if (taps == 0) taps = 32'h8020_0003;
    mks = $urandom;
    do_start(mks);
    for (int w = 0; w < 1000; w++) begin
      if ($urandom_range(0, 99) == 0) begin
        int k;
        k = $urandom_range(0, FRAME_W - 1);
        for (int i = 0; i < k; i++) begin
          send_bit(1'($urandom) ^ mks[0]);
          mks = ks_next(mks, taps);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("rnd_stop_busy", 32'(busy), 0);
        send_bit(1'($urandom));
        send_bit(1'($urandom));
        mks = $urandom;
        do_start(mks);
      end
      pt   = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
      flip = 1'b0;
`ifdef XOR_CIPHER_RX_PARITY_EN
      flip = ($urandom_range(0, 7) == 0);
`endif
      fr = {(^pt) ^ flip, pt};
      exp_q.push_back({flip, pt});
      for (int i = 0; i < FRAME_W; i++) begin
        if ($urandom_range(0, 3) == 0) tick();
        send_bit(fr[i] ^ mks[0]);
        mks = ks_next(mks, taps);
      end
    end

    for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick();
    check("drain_queue", 32'(exp_q.size()), 0);
    check("rnd_overrun", 32'(overrun), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
